// File: rtl/ysyx_22040088_lsu_pkg.sv
// Shared LSU definitions: datapath widths, access-size encodings and FSM states.
package ysyx_22040088_lsu_pkg;

    localparam int LSU_XLEN = 64;
    localparam int LSU_RD_W = 5;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/ysyx_22040088_lsu_align.sv
// Combinational lane logic for the LSU: store lane shift and byte mask,
// load extract/extend, and the natural-alignment check.
module ysyx_22040088_lsu_align
    import ysyx_22040088_lsu_pkg::*;
(
    input  logic [2:0]          addr_lo,
    input  logic [1:0]          size,
    input  logic                is_unsigned,
    input  logic [LSU_XLEN-1:0] store_data,
    input  logic [LSU_XLEN-1:0] rdata,
    output logic [LSU_XLEN-1:0] wdata,
    output logic [7:0]          wmask,
    output logic [LSU_XLEN-1:0] load_data,
    output logic                misalign
);

    logic [5:0]          bit_sh;
    logic [LSU_XLEN-1:0] rep;
    logic [LSU_XLEN-1:0] lane;
    logic [7:0]          base;

    assign bit_sh = {addr_lo, 3'b000};

    always_comb begin
        rep       = '0;
        base      = '0;
        misalign  = 1'b0;
        load_data = '0;
        lane      = rdata >> bit_sh;
        case (size)
            SZ_B: begin
                rep       = {8{store_data[7:0]}};
                base      = 8'h01;
                load_data = is_unsigned ? {56'b0, lane[7:0]} : {{56{lane[7]}}, lane[7:0]};
            end
            SZ_H: begin
                rep       = {4{store_data[15:0]}};
                base      = 8'h03;
                misalign  = addr_lo[0];
                load_data = is_unsigned ? {48'b0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
            end
            SZ_W: begin
                rep       = {2{store_data[31:0]}};
                base      = 8'h0F;
                misalign  = |addr_lo[1:0];
                load_data = is_unsigned ? {32'b0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
            end
            default: begin
                rep       = store_data;
                base      = 8'hFF;
                misalign  = |addr_lo;
                load_data = lane;
            end
        endcase
        // Replication already fills every lane; the shift only places the active one.
        wdata = rep << bit_sh;
        wmask = base << addr_lo;
    end

endmodule

// File: rtl/ysyx_22040088_lsu.sv
// Load/store unit: one data-memory transaction per instruction, results to write-back.
// Non-memory instructions and misaligned accesses skip the bus and complete in one cycle.
module ysyx_22040088_lsu
    import ysyx_22040088_lsu_pkg::*;
#(
    parameter int XLEN = LSU_XLEN,
    parameter int RD_W = LSU_RD_W
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_load,
    input  logic            in_store,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_store_data,
    input  logic [RD_W-1:0] in_rd,
    input  logic            in_rd_wen,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    output logic            mem_req_wen,
    output logic [XLEN-1:0] mem_req_wdata,
    output logic [7:0]      mem_req_wmask,
    input  logic            mem_rsp_valid,
    output logic            mem_rsp_ready,
    input  logic [XLEN-1:0] mem_rsp_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [RD_W-1:0] out_rd,
    output logic            out_rd_wen,
    output logic            out_misalign,
    output logic [1:0]      dbg_state
);

    // Handshakes: a transfer happens on a cycle where valid & ready are both high;
    // once raised, valid and its payload hold unchanged until that transfer.

    lsu_state_t state_q, state_d;

    logic            load_q, store_q, uns_q, out_rd_wen_q, out_mis_q;
    logic [1:0]      size_q;
    logic [XLEN-1:0] addr_q, sdata_q, out_data_q;
    logic [RD_W-1:0] rd_q;

    logic            is_idle, accept, rsp_fire, in_mem, mis;
    logic [2:0]      al_addr_lo;
    logic [1:0]      al_size;
    logic [XLEN-1:0] al_wdata, al_load_data;
    logic [7:0]      al_wmask;

    assign is_idle  = (state_q == ST_IDLE);
    assign in_mem   = in_load | in_store;
    assign accept   = in_valid & in_ready;
    assign rsp_fire = mem_rsp_valid & mem_rsp_ready;

    // In IDLE the alignment check must judge the incoming instruction, not the latched one.
    assign al_addr_lo = is_idle ? in_alu_result[2:0] : addr_q[2:0];
    assign al_size    = is_idle ? in_size : size_q;

    ysyx_22040088_lsu_align u_align (
        .addr_lo    (al_addr_lo),
        .size       (al_size),
        .is_unsigned(uns_q),
        .store_data (sdata_q),
        .rdata      (mem_rsp_rdata),
        .wdata      (al_wdata),
        .wmask      (al_wmask),
        .load_data  (al_load_data),
        .misalign   (mis)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        out_valid     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = (!in_mem || mis) ? ST_OUT : ST_REQ;
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                mem_rsp_ready = 1'b1;
                if (mem_rsp_valid) state_d = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_q       <= 1'b0;
            store_q      <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= 2'b00;
            addr_q       <= '0;
            sdata_q      <= '0;
            rd_q         <= '0;
            out_data_q   <= '0;
            out_rd_wen_q <= 1'b0;
            out_mis_q    <= 1'b0;
        end else if (accept) begin
            load_q       <= in_load;
            store_q      <= in_store;
            uns_q        <= in_unsigned;
            size_q       <= in_size;
            addr_q       <= in_alu_result;
            sdata_q      <= in_store_data;
            rd_q         <= in_rd;
            // Stores, non-mem ops and misaligned accesses all report the address/ALU value.
            out_data_q   <= in_alu_result;
            out_rd_wen_q <= in_rd_wen & ~in_store & ~(in_mem & mis);
            out_mis_q    <= in_mem & mis;
        end else if (rsp_fire && load_q) begin
            out_data_q   <= al_load_data;
        end
    end

    assign mem_req_addr  = mem_req_valid ? {addr_q[XLEN-1:3], 3'b000} : '0;
    assign mem_req_wen   = mem_req_valid & store_q;
    assign mem_req_wdata = mem_req_wen ? al_wdata : '0;
    assign mem_req_wmask = mem_req_wen ? al_wmask : 8'h00;

    assign out_data     = out_data_q;
    assign out_rd       = rd_q;
    assign out_rd_wen   = out_rd_wen_q;
    assign out_misalign = out_mis_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_ysyx_22040088_lsu.sv
// Directed self-checking bench for ysyx_22040088_lsu.
module tb_ysyx_22040088_lsu;
    import ysyx_22040088_lsu_pkg::*;

    logic        clk, rst;
    logic        in_valid, in_ready, in_load, in_store, in_unsigned, in_rd_wen;
    logic [1:0]  in_size;
    logic [63:0] in_alu_result, in_store_data;
    logic [4:0]  in_rd;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_rsp_valid, mem_rsp_ready;
    logic [63:0] mem_rsp_rdata;
    logic        out_valid, out_ready, out_rd_wen, out_misalign;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic [1:0]  dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    ysyx_22040088_lsu dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
        .in_size(in_size), .in_unsigned(in_unsigned), .in_alu_result(in_alu_result),
        .in_store_data(in_store_data), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_rdata(mem_rsp_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_misalign(out_misalign),
        .dbg_state(dbg_state)
    );

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [1:0] st, input string tag);
        int n = 0;
        while (dbg_state !== st && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {62'b0, dbg_state}, {62'b0, st});
    endtask

    task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] sdata,
                         input logic [4:0] rd, input logic rd_wen);
        in_load       = ld;
        in_store      = st;
        in_size       = sz;
        in_unsigned   = uns;
        in_alu_result = addr;
        in_store_data = sdata;
        in_rd         = rd;
        in_rd_wen     = rd_wen;
        in_valid      = 1'b1;
        chk("in_ready_idle", {63'b0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Memory side: wait for the request, check it, grant it, then return one response.
    task automatic mem_txn(input string tag, input logic [63:0] exp_addr, input logic exp_wen,
                           input logic [63:0] exp_wdata, input logic [7:0] exp_wmask,
                           input logic [63:0] rdata);
        wait_state(ST_REQ, {tag, "_req_state"});
        chk({tag, "_req_valid"}, {63'b0, mem_req_valid}, 64'd1);
        chk({tag, "_req_addr"}, mem_req_addr, exp_addr);
        chk({tag, "_req_wen"}, {63'b0, mem_req_wen}, {63'b0, exp_wen});
        if (exp_wen) begin
            chk({tag, "_req_wdata"}, mem_req_wdata, exp_wdata);
            chk({tag, "_req_wmask"}, {56'b0, mem_req_wmask}, {56'b0, exp_wmask});
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk({tag, "_rsp_ready"}, {63'b0, mem_rsp_ready}, 64'd1);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rdata;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
    endtask

    // Scoreboard: compares the write-back beat against the next expected data.
    task automatic check_out(input string tag, input logic [4:0] rd, input logic wen,
                             input logic mis);
        logic [63:0] exp;
        wait_state(ST_OUT, {tag, "_out_state"});
        chk({tag, "_out_valid"}, {63'b0, out_valid}, 64'd1);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s_scoreboard: observed 0x%h expected <empty queue>", tag, out_data);
        end else begin
            exp = exp_q.pop_front();
            chk({tag, "_out_data"}, out_data, exp);
        end
        chk({tag, "_out_rd"}, {59'b0, out_rd}, {59'b0, rd});
        chk({tag, "_out_rd_wen"}, {63'b0, out_rd_wen}, {63'b0, wen});
        chk({tag, "_out_misalign"}, {63'b0, out_misalign}, {63'b0, mis});
        tick();
        chk({tag, "_back_idle"}, {63'b0, in_ready}, 64'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b0;
        in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_size = SZ_B; in_unsigned = 1'b0;
        in_alu_result = '0; in_store_data = '0; in_rd = '0; in_rd_wen = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; out_ready = 1'b1;

        #12;
        chk("rst_state", {62'b0, dbg_state}, {62'b0, ST_IDLE});
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_req_valid", {63'b0, mem_req_valid}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // ALU pass-through: result appears exactly one cycle after accept.
        exp_q.push_back(64'h1234);
        issue(1'b0, 1'b0, SZ_D, 1'b0, 64'h1234, 64'h0, 5'd3, 1'b1);
        chk("pt_latency", {63'b0, out_valid}, 64'd1);
        chk("pt_no_req", {63'b0, mem_req_valid}, 64'd0);
        check_out("pt", 5'd3, 1'b1, 1'b0);

        // Byte at offset 3 of 0x00000000_80FF0000 is 0x80.
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FF80);
        issue(1'b1, 1'b0, SZ_B, 1'b0, 64'h8003, 64'h0, 5'd7, 1'b1);
        mem_txn("lb", 64'h8000, 1'b0, 64'h0, 8'h00, 64'h0000_0000_80FF_0000);
        check_out("lb", 5'd7, 1'b1, 1'b0);

        exp_q.push_back(64'h80);
        issue(1'b1, 1'b0, SZ_B, 1'b1, 64'h8003, 64'h0, 5'd7, 1'b1);
        mem_txn("lbu", 64'h8000, 1'b0, 64'h0, 8'h00, 64'h0000_0000_80FF_0000);
        check_out("lbu", 5'd7, 1'b1, 1'b0);

        // Offset 2 holds 0xFF: all-ones when signed.
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        issue(1'b1, 1'b0, SZ_B, 1'b0, 64'h8002, 64'h0, 5'd8, 1'b1);
        mem_txn("lb2", 64'h8000, 1'b0, 64'h0, 8'h00, 64'h0000_0000_80FF_0000);
        check_out("lb2", 5'd8, 1'b1, 1'b0);

        // Half store into the top lane.
        exp_q.push_back(64'h1006);
        issue(1'b0, 1'b1, SZ_H, 1'b0, 64'h1006, 64'hABCD, 5'd9, 1'b1);
        mem_txn("sh", 64'h1000, 1'b1, 64'hABCD_0000_0000_0000, 8'hC0, 64'h0);
        check_out("sh", 5'd9, 1'b0, 1'b0);

        // Misaligned word load: flagged after one cycle, no bus activity.
        exp_q.push_back(64'h1002);
        issue(1'b1, 1'b0, SZ_W, 1'b0, 64'h1002, 64'h0, 5'd4, 1'b1);
        chk("mis_latency", {63'b0, out_valid}, 64'd1);
        chk("mis_no_req", {63'b0, mem_req_valid}, 64'd0);
        check_out("mis", 5'd4, 1'b0, 1'b1);

        exp_q.push_back(64'hDEAD_BEEF_CAFE_F00D);
        issue(1'b1, 1'b0, SZ_D, 1'b0, 64'h3000, 64'h0, 5'd10, 1'b1);
        mem_txn("ld", 64'h3000, 1'b0, 64'h0, 8'h00, 64'hDEAD_BEEF_CAFE_F00D);
        check_out("ld", 5'd10, 1'b1, 1'b0);

        exp_q.push_back(64'hDEAD);
        issue(1'b1, 1'b0, SZ_H, 1'b1, 64'h3006, 64'h0, 5'd11, 1'b1);
        mem_txn("lhu", 64'h3000, 1'b0, 64'h0, 8'h00, 64'hDEAD_BEEF_CAFE_F00D);
        check_out("lhu", 5'd11, 1'b1, 1'b0);

        exp_q.push_back(64'hFFFF_FFFF_8765_4321);
        issue(1'b1, 1'b0, SZ_W, 1'b0, 64'h2004, 64'h0, 5'd12, 1'b1);
        mem_txn("lw", 64'h2000, 1'b0, 64'h0, 8'h00, 64'h8765_4321_0000_0000);
        check_out("lw", 5'd12, 1'b1, 1'b0);

        // Backpressure: request stall of 5 cycles, then output stall of 3 cycles.
        exp_q.push_back(64'h2004);
        issue(1'b0, 1'b1, SZ_W, 1'b0, 64'h2004, 64'h1122_3344_5566_7788, 5'd13, 1'b1);
        wait_state(ST_REQ, "bp_req_state");
        for (int i = 0; i < 5; i++) begin
            chk("bp_req_valid", {63'b0, mem_req_valid}, 64'd1);
            chk("bp_req_addr", mem_req_addr, 64'h2000);
            chk("bp_req_wdata", mem_req_wdata, 64'h5566_7788_0000_0000);
            chk("bp_req_wmask", {56'b0, mem_req_wmask}, 64'hF0);
            chk("bp_req_in_ready", {63'b0, in_ready}, 64'd0);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("bp_wait_in_ready", {63'b0, in_ready}, 64'd0);
        out_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
            chk("bp_out_data", out_data, 64'h2004);
            chk("bp_out_rd_wen", {63'b0, out_rd_wen}, 64'd0);
            chk("bp_out_in_ready", {63'b0, in_ready}, 64'd0);
            tick();
        end
        out_ready = 1'b1;
        check_out("bp", 5'd13, 1'b0, 1'b0);

        // Reset while waiting on the response; the late response must be ignored.
        issue(1'b1, 1'b0, SZ_D, 1'b0, 64'h4000, 64'h0, 5'd1, 1'b1);
        wait_state(ST_REQ, "rw_req_state");
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("rw_in_wait", {62'b0, dbg_state}, {62'b0, ST_WAIT});
        rst = 1'b0;
        #1;
        chk("rw_state", {62'b0, dbg_state}, {62'b0, ST_IDLE});
        chk("rw_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rw_rsp_ready", {63'b0, mem_rsp_ready}, 64'd0);
        chk("rw_req_addr", mem_req_addr, 64'd0);
        chk("rw_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rw_out_data", out_data, 64'd0);
        chk("rw_out_rd", {59'b0, out_rd}, 64'd0);
        chk("rw_out_rd_wen", {63'b0, out_rd_wen}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'h55;
        tick();
        chk("rw_late_state", {62'b0, dbg_state}, {62'b0, ST_IDLE});
        tick();
        chk("rw_late_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rw_late_out_data", out_data, 64'd0);
        mem_rsp_valid = 1'b0;

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
